// File: rtl/bp_update_ctrl.sv
// Branch-predictor update controller: consumer end of the fetch target queue.
// Pairs in-order resolved branches with the head-entry predictor metadata,
// issues registered training requests and pops the head once all of its
// branches have been trained.
module bp_update_ctrl #(
    parameter  int unsigned VLEN            = 64,
    parameter  int unsigned INSTR_PER_FETCH = 4,
    parameter  int unsigned META_WIDTH      = 32,
    localparam int unsigned CW              = $clog2(INSTR_PER_FETCH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  debug_mode_i,
    input  logic                  res_valid_i,
    output logic                  res_ready_o,
    input  logic [VLEN-1:0]       res_pc_i,
    input  logic                  res_taken_i,
    input  logic                  res_mispredict_i,
    input  logic                  ftq_empty_i,
    input  logic [CW-1:0]         ftq_bp_count_i,
    input  logic [META_WIDTH-1:0] ftq_metadata_i,
    output logic                  ftq_pop_o,
    output logic                  upd_valid_o,
    input  logic                  upd_ready_i,
    output logic [VLEN-1:0]       upd_pc_o,
    output logic                  upd_taken_o,
    output logic                  upd_mispredict_o,
    output logic [META_WIDTH-1:0] upd_metadata_o,
    output logic                  upd_last_o,
    output logic [31:0]           mispred_cnt_o,
    output logic                  err_zero_entry_o
);

    typedef enum logic {ST_EMPTY, ST_HOLD} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         rem_q, rem_d;
    logic                  last_br;
    logic                  train;
    logic                  zero_pop;

    logic                  vld_p1;
    logic [VLEN-1:0]       upd_pc_p1;
    logic                  upd_taken_p1;
    logic                  upd_mis_p1;
    logic [META_WIDTH-1:0] upd_meta_p1;
    logic                  upd_last_p1;
    logic [31:0]           mispred_cnt_q;
    logic                  err_zero_q;

    // Saturating increment for the 32-bit mispredict counter.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Next-state, remaining-branch count, handshake and pop decode.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        res_ready_o = 1'b0;
        ftq_pop_o   = 1'b0;
        zero_pop    = 1'b0;
        train       = 1'b0;
        last_br     = (rem_q == CW'(1));
        case (state_q)
            ST_EMPTY: begin
                if (!ftq_empty_i) begin
                    if (ftq_bp_count_i != '0) begin
                        state_d = ST_HOLD;
                        rem_d   = ftq_bp_count_i;
                    end else begin
                        zero_pop  = 1'b1;
                        ftq_pop_o = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                res_ready_o = !vld_p1 || upd_ready_i;
                train       = res_valid_i && res_ready_o && !debug_mode_i;
                if (train) begin
                    rem_d = rem_q - CW'(1);
                    if (last_br) begin
                        ftq_pop_o = 1'b1;
                        state_d   = ST_EMPTY;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush overrides everything; the pop is also masked while reset is held.
        if (flush_i || !rst_ni) begin
            state_d     = ST_EMPTY;
            rem_d       = '0;
            res_ready_o = 1'b0;
            ftq_pop_o   = 1'b0;
            zero_pop    = 1'b0;
            train       = 1'b0;
        end
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // ---- stage p1: registered predictor update, replaced without a bubble on handshake ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1       <= 1'b0;
            upd_pc_p1    <= '0;
            upd_taken_p1 <= 1'b0;
            upd_mis_p1   <= 1'b0;
            upd_meta_p1  <= '0;
            upd_last_p1  <= 1'b0;
        end else if (flush_i) begin
            vld_p1 <= 1'b0;
        end else if (train) begin
            vld_p1       <= 1'b1;
            upd_pc_p1    <= res_pc_i;
            upd_taken_p1 <= res_taken_i;
            upd_mis_p1   <= res_mispredict_i;
            upd_meta_p1  <= ftq_metadata_i;
            upd_last_p1  <= last_br;
        end else if (upd_ready_i) begin
            vld_p1 <= 1'b0;
        end
    end

    // Mispredict statistics and sticky zero-branch-entry error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mispred_cnt_q <= '0;
            err_zero_q    <= 1'b0;
        end else begin
            if (train && res_mispredict_i) begin
                mispred_cnt_q <= sat_inc32(mispred_cnt_q);
            end
            if (zero_pop) begin
                err_zero_q <= 1'b1;
            end
        end
    end

    assign upd_valid_o      = vld_p1;
    assign upd_pc_o         = upd_pc_p1;
    assign upd_taken_o      = upd_taken_p1;
    assign upd_mispredict_o = upd_mis_p1;
    assign upd_metadata_o   = upd_meta_p1;
    assign upd_last_o       = upd_last_p1;
    assign mispred_cnt_o    = mispred_cnt_q;
    assign err_zero_entry_o = err_zero_q;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Self-checking bench for bp_update_ctrl: directed scenarios plus a randomized
// run scored against a transaction-level model of the FTQ/branch pairing.
module tb_bp_update_ctrl;
    localparam int VLEN = 64;
    localparam int IPF  = 4;
    localparam int MW   = 32;
    localparam int CW   = $clog2(IPF) + 1;
    localparam int NENT = 600;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush_i, debug_mode_i, res_valid_i, res_ready_o;
    logic [VLEN-1:0] res_pc_i;
    logic            res_taken_i, res_mispredict_i, ftq_empty_i;
    logic [CW-1:0]   ftq_bp_count_i;
    logic [MW-1:0]   ftq_metadata_i;
    logic            ftq_pop_o, upd_valid_o, upd_ready_i;
    logic [VLEN-1:0] upd_pc_o;
    logic            upd_taken_o, upd_mispredict_o;
    logic [MW-1:0]   upd_metadata_o;
    logic            upd_last_o;
    logic [31:0]     mispred_cnt_o;
    logic            err_zero_entry_o;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic            taken;
        logic            mis;
        logic [MW-1:0]   meta;
        logic            last;
    } upd_t;

    bp_update_ctrl #(.VLEN(VLEN), .INSTR_PER_FETCH(IPF), .META_WIDTH(MW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
        .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_pc_i(res_pc_i),
        .res_taken_i(res_taken_i), .res_mispredict_i(res_mispredict_i),
        .ftq_empty_i(ftq_empty_i), .ftq_bp_count_i(ftq_bp_count_i),
        .ftq_metadata_i(ftq_metadata_i), .ftq_pop_o(ftq_pop_o),
        .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i), .upd_pc_o(upd_pc_o),
        .upd_taken_o(upd_taken_o), .upd_mispredict_o(upd_mispredict_o),
        .upd_metadata_o(upd_metadata_o), .upd_last_o(upd_last_o),
        .mispred_cnt_o(mispred_cnt_o), .err_zero_entry_o(err_zero_entry_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic idle();
        flush_i = 0; debug_mode_i = 0; res_valid_i = 0; res_pc_i = '0;
        res_taken_i = 0; res_mispredict_i = 0; ftq_empty_i = 1;
        ftq_bp_count_i = '0; ftq_metadata_i = '0; upd_ready_i = 1;
    endtask

    task automatic apply_reset();
        idle();
        rst_ni = 0;
        cyc();
        cyc();
        rst_ni = 1;
    endtask

    task automatic test_reset();
        idle();
        rst_ni = 0;
        smp();
        checks++; if (upd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_upd_valid: got %b want 0", upd_valid_o); end
        checks++; if (upd_pc_o !== '0 || upd_metadata_o !== '0 || upd_last_o !== 1'b0) begin errors++; $display("FAIL reset_payload: pc %h meta %h last %b want zeros", upd_pc_o, upd_metadata_o, upd_last_o); end
        checks++; if (ftq_pop_o !== 1'b0 || res_ready_o !== 1'b0) begin errors++; $display("FAIL reset_pop_ready: pop %b ready %b want 0 0", ftq_pop_o, res_ready_o); end
        checks++; if (mispred_cnt_o !== 32'd0 || err_zero_entry_o !== 1'b0) begin errors++; $display("FAIL reset_stats: cnt %h err %b want 0 0", mispred_cnt_o, err_zero_entry_o); end
        cyc();
        rst_ni = 1;
    endtask

    task automatic test_two_branch();
        int pops = 0;
        apply_reset();
        ftq_empty_i = 0; ftq_bp_count_i = CW'(2); ftq_metadata_i = 32'hA5A5_0001;
        smp();
        checks++; if (res_ready_o !== 1'b0) begin errors++; $display("FAIL tb_load_ready: got %b want 0", res_ready_o); end
        cyc();
        res_valid_i = 1; res_pc_i = 64'h8000_0010; res_taken_i = 1; res_mispredict_i = 0;
        smp();
        if (ftq_pop_o) pops++;
        checks++; if (res_ready_o !== 1'b1 || ftq_pop_o !== 1'b0) begin errors++; $display("FAIL tb_first_accept: ready %b pop %b want 1 0", res_ready_o, ftq_pop_o); end
        cyc();
        res_pc_i = 64'h8000_0014; res_taken_i = 0;
        smp();
        if (ftq_pop_o) pops++;
        checks++; if ({upd_valid_o, upd_pc_o, upd_taken_o, upd_metadata_o, upd_last_o} !== {1'b1, 64'h8000_0010, 1'b1, 32'hA5A5_0001, 1'b0}) begin errors++; $display("FAIL tb_upd0: v %b pc %h t %b meta %h last %b want 1 80000010 1 a5a50001 0", upd_valid_o, upd_pc_o, upd_taken_o, upd_metadata_o, upd_last_o); end
        checks++; if (res_ready_o !== 1'b1 || ftq_pop_o !== 1'b1) begin errors++; $display("FAIL tb_second_accept: ready %b pop %b want 1 1", res_ready_o, ftq_pop_o); end
        cyc();
        res_valid_i = 0; ftq_empty_i = 1;
        smp();
        if (ftq_pop_o) pops++;
        checks++; if ({upd_valid_o, upd_pc_o, upd_taken_o, upd_metadata_o, upd_last_o} !== {1'b1, 64'h8000_0014, 1'b0, 32'hA5A5_0001, 1'b1}) begin errors++; $display("FAIL tb_upd1: v %b pc %h t %b meta %h last %b want 1 80000014 0 a5a50001 1", upd_valid_o, upd_pc_o, upd_taken_o, upd_metadata_o, upd_last_o); end
        cyc();
        smp();
        if (ftq_pop_o) pops++;
        checks++; if (upd_valid_o !== 1'b0) begin errors++; $display("FAIL tb_drop: upd_valid %b want 0", upd_valid_o); end
        checks++; if (pops != 1) begin errors++; $display("FAIL tb_pop_count: got %0d want 1", pops); end
    endtask

    task automatic test_stall();
        int pops = 0;
        apply_reset();
        upd_ready_i = 0; ftq_empty_i = 0; ftq_bp_count_i = CW'(1); ftq_metadata_i = 32'h1111_0001;
        smp();
        cyc();
        res_valid_i = 1; res_pc_i = 64'h8000_0100; res_taken_i = 1; res_mispredict_i = 1;
        smp();
        checks++; if (res_ready_o !== 1'b1 || ftq_pop_o !== 1'b1) begin errors++; $display("FAIL stall_first: ready %b pop %b want 1 1", res_ready_o, ftq_pop_o); end
        cyc();
        ftq_bp_count_i = CW'(2); ftq_metadata_i = 32'h2222_0002;
        res_pc_i = 64'h8000_0104; res_taken_i = 0; res_mispredict_i = 0;
        for (int i = 0; i < 5; i++) begin
            smp();
            if (ftq_pop_o) pops++;
            checks++; if ({upd_valid_o, upd_pc_o, upd_metadata_o, res_ready_o} !== {1'b1, 64'h8000_0100, 32'h1111_0001, 1'b0}) begin errors++; $display("FAIL stall_hold%0d: v %b pc %h meta %h ready %b want 1 80000100 11110001 0", i, upd_valid_o, upd_pc_o, upd_metadata_o, res_ready_o); end
            cyc();
        end
        upd_ready_i = 1;
        smp();
        if (ftq_pop_o) pops++;
        checks++; if (res_ready_o !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", res_ready_o); end
        checks++; if (pops != 0) begin errors++; $display("FAIL stall_extra_pop: got %0d want 0", pops); end
        cyc();
        res_valid_i = 0;
        smp();
        checks++; if ({upd_valid_o, upd_pc_o, upd_metadata_o, upd_last_o} !== {1'b1, 64'h8000_0104, 32'h2222_0002, 1'b0}) begin errors++; $display("FAIL stall_second_upd: v %b pc %h meta %h last %b want 1 80000104 22220002 0", upd_valid_o, upd_pc_o, upd_metadata_o, upd_last_o); end
        cyc();
    endtask

    task automatic test_zero_entry();
        apply_reset();
        ftq_empty_i = 0; ftq_bp_count_i = '0; ftq_metadata_i = 32'h0;
        smp();
        checks++; if (ftq_pop_o !== 1'b1 || err_zero_entry_o !== 1'b0) begin errors++; $display("FAIL zero_pop: pop %b err %b want 1 0", ftq_pop_o, err_zero_entry_o); end
        cyc();
        ftq_bp_count_i = CW'(1); ftq_metadata_i = 32'h3333_0003;
        smp();
        checks++; if ({err_zero_entry_o, ftq_pop_o, res_ready_o, upd_valid_o} !== 4'b1000) begin errors++; $display("FAIL zero_after: err %b pop %b ready %b v %b want 1 0 0 0", err_zero_entry_o, ftq_pop_o, res_ready_o, upd_valid_o); end
        cyc();
        res_valid_i = 1; res_pc_i = 64'h8000_0200;
        smp();
        checks++; if (ftq_pop_o !== 1'b1 || res_ready_o !== 1'b1) begin errors++; $display("FAIL zero_next_accept: pop %b ready %b want 1 1", ftq_pop_o, res_ready_o); end
        cyc();
        res_valid_i = 0; ftq_empty_i = 1;
        smp();
        checks++; if ({upd_valid_o, upd_metadata_o, upd_last_o, err_zero_entry_o} !== {1'b1, 32'h3333_0003, 1'b1, 1'b1}) begin errors++; $display("FAIL zero_next_upd: v %b meta %h last %b err %b want 1 33330003 1 1", upd_valid_o, upd_metadata_o, upd_last_o, err_zero_entry_o); end
        cyc();
        smp();
        checks++; if (upd_valid_o !== 1'b0 || err_zero_entry_o !== 1'b1) begin errors++; $display("FAIL zero_sticky: v %b err %b want 0 1", upd_valid_o, err_zero_entry_o); end
    endtask

    task automatic test_debug();
        apply_reset();
        ftq_empty_i = 0; ftq_bp_count_i = CW'(1); ftq_metadata_i = 32'h4444_0004;
        smp();
        cyc();
        res_valid_i = 1; debug_mode_i = 1; res_pc_i = 64'h8000_0300; res_mispredict_i = 1;
        smp();
        checks++; if (res_ready_o !== 1'b1 || ftq_pop_o !== 1'b0) begin errors++; $display("FAIL dbg_consume: ready %b pop %b want 1 0", res_ready_o, ftq_pop_o); end
        cyc();
        debug_mode_i = 0; res_pc_i = 64'h8000_0304; res_mispredict_i = 0;
        smp();
        checks++; if ({upd_valid_o, ftq_pop_o, res_ready_o} !== 3'b011) begin errors++; $display("FAIL dbg_next: v %b pop %b ready %b want 0 1 1", upd_valid_o, ftq_pop_o, res_ready_o); end
        cyc();
        res_valid_i = 0; ftq_empty_i = 1;
        smp();
        checks++; if ({upd_valid_o, upd_pc_o, upd_last_o} !== {1'b1, 64'h8000_0304, 1'b1} || mispred_cnt_o !== 32'd0) begin errors++; $display("FAIL dbg_upd: v %b pc %h last %b cnt %h want 1 80000304 1 0", upd_valid_o, upd_pc_o, upd_last_o, mispred_cnt_o); end
        cyc();
    endtask

    task automatic test_flush();
        apply_reset();
        upd_ready_i = 0; ftq_empty_i = 0; ftq_bp_count_i = CW'(2); ftq_metadata_i = 32'h5555_0005;
        smp();
        cyc();
        res_valid_i = 1; res_pc_i = 64'h8000_0400; res_mispredict_i = 1;
        smp();
        cyc();
        upd_ready_i = 1; flush_i = 1; res_pc_i = 64'h8000_0404;
        smp();
        checks++; if ({upd_valid_o, res_ready_o, ftq_pop_o} !== 3'b100) begin errors++; $display("FAIL flush_cycle: v %b ready %b pop %b want 1 0 0", upd_valid_o, res_ready_o, ftq_pop_o); end
        cyc();
        flush_i = 0; res_valid_i = 0; ftq_empty_i = 1;
        smp();
        checks++; if (upd_valid_o !== 1'b0 || res_ready_o !== 1'b0 || mispred_cnt_o !== 32'd1) begin errors++; $display("FAIL flush_after: v %b ready %b cnt %h want 0 0 1", upd_valid_o, res_ready_o, mispred_cnt_o); end
        cyc();
        ftq_empty_i = 0; ftq_bp_count_i = CW'(1); ftq_metadata_i = 32'h6666_0006; res_valid_i = 1;
        smp();
        checks++; if (res_ready_o !== 1'b0) begin errors++; $display("FAIL flush_empty_state: ready %b want 0", res_ready_o); end
        cyc();
        smp();
        checks++; if (res_ready_o !== 1'b1 || ftq_pop_o !== 1'b1) begin errors++; $display("FAIL flush_reload: ready %b pop %b want 1 1", res_ready_o, ftq_pop_o); end
        cyc();
        res_valid_i = 0; ftq_empty_i = 1;
    endtask

    task automatic test_random();
        int    ent_cnt[NENT];
        logic [MW-1:0] ent_meta[NENT];
        int    avail = 0, drv_head = 0, mdl_head = 0, mdl_used = 0, exp_mis = 0;
        upd_t  expq[$];
        upd_t  e, got;
        logic  acc, pop;
        for (int i = 0; i < NENT; i++) begin
            ent_cnt[i]  = ($urandom % 10 == 0) ? 0 : 1 + int'($urandom % IPF);
            ent_meta[i] = $urandom;
        end
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            if (avail < NENT && ($urandom % 2) == 1) avail++;
            ftq_empty_i      = (drv_head >= avail);
            ftq_bp_count_i   = ftq_empty_i ? '0 : CW'(ent_cnt[drv_head]);
            ftq_metadata_i   = ftq_empty_i ? '0 : ent_meta[drv_head];
            res_valid_i      = ($urandom % 3) != 0;
            res_pc_i         = {$urandom, $urandom};
            res_taken_i      = 1'($urandom);
            res_mispredict_i = 1'($urandom);
            debug_mode_i     = ($urandom % 10) == 0;
            upd_ready_i      = ($urandom % 4) != 0;
            smp();
            acc = res_valid_i && res_ready_o;
            pop = ftq_pop_o;
            if (upd_valid_o && upd_ready_i) begin
                checks++;
                got = {upd_pc_o, upd_taken_o, upd_mispredict_o, upd_metadata_o, upd_last_o};
                if (expq.size() == 0) begin
                    errors++; $display("FAIL rnd_unexpected_upd: cycle %0d got pc %h with nothing expected", c, upd_pc_o);
                end else begin
                    e = expq.pop_front();
                    if (got !== e) begin errors++; $display("FAIL rnd_upd: cycle %0d got pc %h t %b m %b meta %h last %b want pc %h t %b m %b meta %h last %b", c, got.pc, got.taken, got.mis, got.meta, got.last, e.pc, e.taken, e.mis, e.meta, e.last); end
                end
            end
            if (acc && !debug_mode_i) begin
                while (mdl_head < NENT - 1 && ent_cnt[mdl_head] == 0) mdl_head++;
                e.pc = res_pc_i; e.taken = res_taken_i; e.mis = res_mispredict_i;
                e.meta = ent_meta[mdl_head];
                e.last = (mdl_used + 1 == ent_cnt[mdl_head]);
                expq.push_back(e);
                if (res_mispredict_i) exp_mis++;
                checks++; if (pop !== e.last) begin errors++; $display("FAIL rnd_pop_on_accept: cycle %0d got %b want %b", c, pop, e.last); end
                if (e.last) begin mdl_head++; mdl_used = 0; end
                else mdl_used++;
            end else if (acc) begin
                checks++; if (pop !== 1'b0) begin errors++; $display("FAIL rnd_debug_pop: cycle %0d got %b want 0", c, pop); end
            end else if (pop) begin
                checks++; if (ftq_empty_i !== 1'b0 || ftq_bp_count_i !== '0) begin errors++; $display("FAIL rnd_stray_pop: cycle %0d popped entry with count %0d empty %b", c, ftq_bp_count_i, ftq_empty_i); end
            end
            if (pop) drv_head++;
            cyc();
        end
        res_valid_i = 0; upd_ready_i = 1; debug_mode_i = 0; ftq_empty_i = 1;
        for (int c = 0; c < 4; c++) begin
            smp();
            if (upd_valid_o) begin
                checks++;
                got = {upd_pc_o, upd_taken_o, upd_mispredict_o, upd_metadata_o, upd_last_o};
                if (expq.size() == 0) begin
                    errors++; $display("FAIL rnd_drain_unexpected: got pc %h", upd_pc_o);
                end else begin
                    e = expq.pop_front();
                    if (got !== e) begin errors++; $display("FAIL rnd_drain_upd: got pc %h meta %h last %b want pc %h meta %h last %b", got.pc, got.meta, got.last, e.pc, e.meta, e.last); end
                end
            end
            cyc();
        end
        checks++; if (expq.size() != 0) begin errors++; $display("FAIL rnd_lost_updates: %0d expected updates never issued, want 0", expq.size()); end
        checks++; if (mispred_cnt_o !== 32'(exp_mis)) begin errors++; $display("FAIL rnd_mispred_cnt: got %0d want %0d", mispred_cnt_o, exp_mis); end
    endtask

    task automatic test_saturation_and_async_reset();
        apply_reset();
        ftq_empty_i = 0; ftq_bp_count_i = CW'(4); ftq_metadata_i = 32'h7777_0007; upd_ready_i = 1;
        force dut.mispred_cnt_q = 32'hFFFF_FFFE;
        smp();
        cyc();
        release dut.mispred_cnt_q;
        smp();
        checks++; if (mispred_cnt_o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_preload: got %h want fffffffe", mispred_cnt_o); end
        res_valid_i = 1; res_mispredict_i = 1;
        for (int i = 0; i < 3; i++) begin
            res_pc_i = 64'h8000_0500 + 64'(4 * i);
            @(posedge clk_i);
            #1;
            checks++; if (mispred_cnt_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_cnt%0d: got %h want ffffffff", i, mispred_cnt_o); end
        end
        res_valid_i = 0; upd_ready_i = 0;
        #2;
        checks++; if (upd_valid_o !== 1'b1) begin errors++; $display("FAIL sat_pending: v %b want 1", upd_valid_o); end
        rst_ni = 0;
        #1;
        checks++; if ({upd_valid_o, upd_last_o, ftq_pop_o, res_ready_o, err_zero_entry_o} !== 5'b0 || upd_pc_o !== '0 || upd_metadata_o !== '0 || mispred_cnt_o !== 32'd0) begin errors++; $display("FAIL async_reset: v %b pc %h meta %h cnt %h pop %b ready %b want all zero", upd_valid_o, upd_pc_o, upd_metadata_o, mispred_cnt_o, ftq_pop_o, res_ready_o); end
        cyc();
        rst_ni = 1;
    endtask

    initial begin
        idle();
        test_reset();
        test_two_branch();
        test_stall();
        test_zero_entry();
        test_debug();
        test_flush();
        test_random();
        test_saturation_and_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bp_update_ctrl.md
Name: bp_update_ctrl

Overview:
- Consumer end of the fetch target queue (FTQ). Accepts in-order resolved-branch results from the backend and pairs each one with the predictor metadata at the FTQ head.
- Emits registered training requests to the branch predictor.
- Pops the FTQ head once every branch recorded in that entry has been trained.
- Sits between the backend branch unit, the FTQ read port and the predictor update port.

Parameters:
- VLEN, 64, virtual address width.
- INSTR_PER_FETCH, 4, instructions per fetch block. Power of two, at least 2.
- META_WIDTH, 32, width of the predictor metadata word.
- CW, $clog2(INSTR_PER_FETCH)+1, width of the per-entry branch count (derived; do not override).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush
- debug_mode_i  in  1  core in debug mode
- res_valid_i  in  1  resolved-branch valid
- res_ready_o  out  1  resolved branch accepted
- res_pc_i  in  VLEN  branch PC
- res_taken_i  in  1  actual direction
- res_mispredict_i  in  1  prediction was wrong
- ftq_empty_i  in  1  FTQ has no entry
- ftq_bp_count_i  in  CW  number of branches in the head entry
- ftq_metadata_i  in  META_WIDTH  head-entry metadata
- ftq_pop_o  out  1  pop FTQ head (single-cycle pulse)
- upd_valid_o  out  1  predictor update valid
- upd_ready_i  in  1  predictor accepts the update
- upd_pc_o  out  VLEN  update PC
- upd_taken_o  out  1  update direction
- upd_mispredict_o  out  1  update mispredict flag
- upd_metadata_o  out  META_WIDTH  update metadata
- upd_last_o  out  1  update is the last branch of its FTQ entry
- mispred_cnt_o  out  32  saturating count of issued mispredict updates
- err_zero_entry_o  out  1  sticky flag: an FTQ entry with zero branches was seen

Behaviour:
- Reset (asynchronous, active-low): state EMPTY, rem_q=0, all upd_* outputs 0, ftq_pop_o=0, res_ready_o=0, mispred_cnt_o=0, err_zero_entry_o=0.
- State EMPTY:
  - If !ftq_empty_i and ftq_bp_count_i!=0: load rem_q=ftq_bp_count_i and go to HOLD. This costs one cycle of latency; res_ready_o=0 in that cycle.
  - If !ftq_empty_i and ftq_bp_count_i==0: assert ftq_pop_o, set err_zero_entry_o, stay in EMPTY.
  - If ftq_empty_i: stay in EMPTY.
- State HOLD:
  - res_ready_o = !upd_valid_o || upd_ready_i. res_ready_o is combinational and has no dependency on res_valid_i.
- Accept condition: res_valid_i && res_ready_o.
- On accept with debug_mode_i=0:
  - Output register loads pc/taken/mispredict from the res_* inputs and metadata from ftq_metadata_i. upd_valid_o=1 on the next cycle.
  - upd_last_o=(rem_q==1).
  - rem_q decrements.
  - If rem_q==1: ftq_pop_o=1 in the same cycle and next state is EMPTY.
  - mispred_cnt_o increments when res_mispredict_i=1 and saturates at 0xFFFF_FFFF.
- On accept with debug_mode_i=1: the result is consumed and dropped. No update is issued, rem_q is unchanged, no pop.
- Output handshake:
  - upd_valid_o holds with stable payload until upd_ready_i.
  - If an accept and upd_ready_i coincide, the new payload replaces the old one with no bubble, giving one update per cycle of throughput.
  - With no new accept, upd_valid_o drops the cycle after the handshake.
- Arithmetic: rem_q has width CW; ftq_bp_count_i > INSTR_PER_FETCH is not produced upstream and is not checked. In EMPTY state rem_q is 0.
- flush_i has priority over every same-cycle event:
  - Next state EMPTY, rem_q=0, upd_valid_o=0 next cycle (pending update discarded).
  - ftq_pop_o forced 0 and res_ready_o forced 0 in the flush cycle.
  - mispred_cnt_o and err_zero_entry_o are kept.
- upd_ready_i low for an unbounded time: res_ready_o stays low and the FTQ head is not popped; no result is lost.

Test Plan:
- Head entry count=2, metadata 0xA5A5_0001; resolutions PC 0x8000_0010 (taken) and 0x8000_0014 (not taken), upd_ready_i=1 -> two updates on consecutive cycles, both with metadata 0xA5A5_0001. upd_last_o=0 then 1. ftq_pop_o pulses once, with the second accept.
- Count=1 entry, upd_ready_i held 0 for 5 cycles -> upd_valid_o stays 1 with stable payload; a second result waits with res_ready_o=0; ftq_pop_o=1 exactly once (with the first accept) and no second pop; the second result is accepted in the cycle upd_ready_i rises.
- Head entry with count=0 -> ftq_pop_o pulses, err_zero_entry_o=1 and stays set, no update issued, next entry then loads normally.
- debug_mode_i=1 during a resolution of a count=1 entry -> result consumed, no upd_valid_o, no pop, rem_q stays 1; the next non-debug resolution trains and pops.
- flush_i in the same cycle as an accept with rem_q=1 and a pending upd_valid_o -> no pop, no new update, upd_valid_o=0 next cycle, state EMPTY, mispred_cnt_o unchanged.
- mispred_cnt_o preloaded near saturation (via 0xFFFF_FFFF mispredict accepts, or force at 0xFFFF_FFFE), then 3 mispredict updates -> counter stops at 0xFFFF_FFFF. Asserting rst_ni=0 mid-transfer immediately clears all outputs asynchronously.
